fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RD_LAT, default 2, memory read latency in cycles from the rden cycle to valid mem_q; legal range 1..4.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  fetch request; sampled only while busy=0.
REQ-005 pc  input  32  byte address of the instruction; sampled with start; only pc[15:0] is used.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 fault  output  1  valid while done=1; 1 = misaligned pc, no fetch performed.
REQ-009 instr  output  32  last successfully fetched instruction; held between fetches.
REQ-010 mem_rden  output  1  byte-RAM read enable.
REQ-011 mem_addr  output  16  byte-RAM address.
REQ-012 mem_q  input  8  byte-RAM read data, valid RD_LAT cycles after the mem_rden cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT, CAPTURE and DONE, plus a byte index k (2 bits) and a wait counter.
REQ-014 IDLE: on start=1 with pc[1:0]=00, latch base=pc[15:0], clear k, go to ISSUE.
REQ-015 IDLE: on start=1 with pc[1:0]!=00, go to DONE with fault latched as 1; no mem_rden is issued.
REQ-016 ISSUE (1 cycle): drive mem_rden=1 and mem_addr=base+k (mod 2^16), then go to WAIT.
REQ-017 WAIT: hold mem_rden=0 and mem_addr unchanged for RD_LAT-1 cycles, then go to CAPTURE; with RD_LAT=1, skip WAIT and go directly to CAPTURE.
REQ-018 CAPTURE (1 cycle): write mem_q into shadow byte lane k, so the shadow register is little-endian (byte at base lands in bits [7:0]).
REQ-019 CAPTURE exit: if k<3, increment k and go to ISSUE; if k=3, go to DONE.
REQ-020 DONE (1 cycle): done=1. If fault=0, instr is updated from the shadow register on entry to DONE. Return to IDLE.
REQ-021 instr SHALL NOT change at any time other than on entry to a non-fault DONE.
REQ-022 Latency: done is high exactly 4*(RD_LAT+1)+1 cycles after the cycle in which start is accepted (13 cycles for RD_LAT=2); a misaligned start gives done after exactly 1 cycle.
REQ-023 mem_rden SHALL be high for exactly 4 cycles per aligned fetch, each 1 cycle wide, with addresses base, base+1, base+2, base+3.
REQ-024 start while busy=1, including during the DONE cycle, SHALL be ignored and not queued.
REQ-025 fault SHALL be held until the next accepted start; it is cleared on that acceptance.
REQ-026 pc[31:16] SHALL be ignored; no range check is performed.
REQ-027 mem_addr SHALL hold its last driven value when outside ISSUE.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE;
- busy=0, done=0, fault=0;
- instr=32'h0, shadow register=32'h0;
- mem_rden=0, mem_addr=16'h0;
- k=0, wait counter=0.
REQ-029 Reset asserted mid-fetch SHALL abort the fetch, leave instr=0, and issue no further mem_rden.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 RAM[0x0010..0x0013]=13,05,A0,00; start with pc=0x10 -> mem_rden at 0x10/11/12/13; done 13 cycles later; instr=0x00A00513; fault=0.
REQ-032 pc=0x0000FFFC, RAM[0xFFFC..F]=EF,00,00,00 -> instr=0x000000EF; addresses 0xFFFC..0xFFFF; no wrap.
REQ-033 pc=0x12 with instr previously 0x00A00513 -> done 1 cycle later, fault=1, no mem_rden, instr stays 0x00A00513.
REQ-034 Pulse start again 3 cycles after acceptance with pc=0x40 -> ignored; the original fetch completes and only 4 mem_rden pulses occur.
REQ-035 Assert rst during CAPTURE of byte 2 -> busy=0, mem_rden=0, instr=0 without a clk edge; a fetch after release completes normally.
REQ-036 RD_LAT=1 and RD_LAT=4 runs of the REQ-031 fetch -> done at 9 and 21 cycles respectively, with the same instr value.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Fetches one 32-bit instruction from a byte-wide synchronous RAM by issuing
// four single-byte reads (base, base+1, base+2, base+3). The bytes are
// assembled little-endian into a shadow register. The shadow register is
// copied to the instruction output when the fetch completes. A start with a
// misaligned pc (pc[1:0] != 0) does not access the RAM. Instead it completes
// on the next cycle with fault set.
//
// Parameters
//   RD_LAT    : RAM read latency in cycles, from the mem_rden cycle until
//               mem_q is valid (legal range 1..4)
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   start     : fetch request, sampled only while busy is low
//   pc        : byte address of the instruction (only pc[15:0] is used)
//   busy      : high whenever the unit is not idle
//   done      : one-cycle completion pulse
//   fault     : 1 = misaligned pc; valid with done, held until the next start
//   instr     : last successfully fetched instruction
//   mem_rden  : byte-RAM read enable
//   mem_addr  : byte-RAM address (holds its last value outside a read issue)
//   mem_q     : byte-RAM read data
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] instr,
    output logic        mem_rden,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_q
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // The wait counter runs 0 .. RD_LAT-2. WAIT is never entered when
    // RD_LAT is 1, so the terminal value only matters for RD_LAT >= 2.
    localparam logic [2:0] WAIT_LAST = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [2:0]  wait_q, wait_d;
    logic [15:0] base_q, base_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rden_q, rden_d;
    logic [15:0] addr_q, addr_d;

    // The upper pc half carries no meaning for this unit.
    logic        pc_hi_unused_s;
    assign pc_hi_unused_s = ^pc[31:16];

    // Next-state and next-output logic for the fetch sequencer
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wait_d   = wait_q;
        base_d   = base_q;
        shadow_d = shadow_q;
        instr_d  = instr_q;
        fault_d  = fault_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pc[1:0] == 2'b00) begin
                        base_d  = pc[15:0];
                        k_d     = 2'd0;
                        fault_d = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_d = 3'd0;
                if (RD_LAT == 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 3'd0;
                    state_d = S_CAPTURE;
                end else begin
                    wait_d  = wait_q + 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_CAPTURE: begin
                shadow_d[{k_q, 3'b000} +: 8] = mem_q;
                if (k_q == 2'd3) begin
                    // The last byte is merged here so that instr already
                    // holds the full word in the DONE cycle.
                    if (!fault_q) begin
                        instr_d = shadow_d;
                    end else begin
                        instr_d = instr_q;
                    end
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The outputs are registered copies of the next state. As a result,
        // they line up with the state register and do not glitch.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        rden_d = (state_d == S_ISSUE);
        if (state_d == S_ISSUE) begin
            addr_d = base_d + {14'd0, k_d};
        end else begin
            addr_d = addr_q;
        end
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= 2'd0;
            wait_q   <= 3'd0;
            base_q   <= 16'h0000;
            shadow_q <= 32'h0000_0000;
            instr_q  <= 32'h0000_0000;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
            base_q   <= base_d;
            shadow_q <= shadow_d;
            instr_q  <= instr_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign instr    = instr_q;
    assign mem_rden = rden_q;
    assign mem_addr = addr_q;

endmodule
